sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL provide parameter W, default 33, data word width in bits (1..64).
REQ-002 SHALL provide parameter AW, default 11, address width; DEPTH = 2**AW words, all usable.
REQ-003 SHALL provide parameter CW, default 16, drop-counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-005 Ports:
 clk  in  1  rising-edge clock
 rst  in  1  asynchronous active-high reset
 d  in  W  write data
 wen  in  1  write request
 ren  in  1  read request
 flush  in  1  synchronous pointer clear
 clr  in  1  synchronous clear of status (flags, drop count, high-water)
 afull_thr  in  AW+1  nearly-full threshold, in words
 q  out  W  registered read data
 nempty  out  1  count != 0
 full  out  1  count == DEPTH
 nearlyfull  out  1  registered, count >= afull_thr
 nwords  out  AW+1  current count
 hiwater  out  AW+1  peak count since reset/clr
 ovf  out  1  sticky, write refused
 udf  out  1  sticky, read while empty
 ndrop  out  CW  refused-write count, saturating

Function
REQ-010 Pointers SHALL be AW+1 bits; count = wptr - rptr mod 2**(AW+1), combinational on registered pointers.
REQ-011 Write SHALL be accepted iff wen and (count < DEPTH or (ren and count > 0)); accepted word stored at wptr[AW-1:0], wptr increments.
REQ-012 Read SHALL be performed iff ren and count > 0: q <= mem[rptr] at that edge, rptr increments; read latency one clock.
REQ-013 ren with count == 0 SHALL load q <= 0 and set udf, even with simultaneous wen (no fall-through).
REQ-014 ren low SHALL hold q.
REQ-015 Refused write SHALL set ovf and increment ndrop, saturating at 2**CW-1.
REQ-016 Word written at edge N SHALL raise nempty after edge N and be readable by ren at edge N+1.
REQ-017 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-018 nearlyfull SHALL register (next count >= afull_thr); afull_thr = 0 forces it high.
REQ-019 hiwater SHALL register max(hiwater, next count) each cycle.
REQ-020 flush SHALL set wptr = rptr = 0 and take priority: concurrent wen/ren ignored, no drop, no udf; q holds.
REQ-021 clr SHALL zero ovf, udf, ndrop, hiwater; same-cycle events SHALL win over clr (flag/counter reflects the new event).
REQ-022 Pointer wrap at 2**(AW+1) SHALL be seamless.

Reset
REQ-030 rst SHALL asynchronously zero wptr, rptr, q, nearlyfull, hiwater, ovf, udf, ndrop; nempty=0, full=0, nwords=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 rst asserted mid-operation SHALL discard all stored words; first write after release lands at address 0.

Structure
REQ-040 Shared package fifo_pkg SHALL hold default W, AW, CW and the 33-bit event-word width.
REQ-041 Storage SHALL be a sub-module fifo_sdp_ram (one write port, one registered read port) inferable as block RAM.

Verification
REQ-050 W=33, AW=4: reset, write 0x1_0000_0001..0x1_0000_0010 (16 words) -> full=1, nwords=16; read 16 -> same order, nempty=0 after last.
REQ-051 Full FIFO, wen+ren same cycle -> write accepted, count stays 16, ovf=0, ndrop=0.
REQ-052 Full FIFO, 3 writes without ren -> ovf=1, ndrop=3; clr -> ovf=0, ndrop=0, hiwater=16 cleared to current count on the following cycle.
REQ-053 Empty FIFO, ren+wen of 0x5 -> q=0, udf=1; next ren -> q=0x5.
REQ-054 afull_thr=12: write 11 -> nearlyfull=0; write 12th -> nearlyfull=1 one edge later; flush -> nwords=0, nearlyfull=0 next edge.
REQ-055 Stream 100 words through with count cycling 0..5 (pointer wrap) then assert rst mid-stream -> all outputs 0 immediately, next written word read back correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults for the parameterised synchronous FIFO and its storage.
// The event word is the 33-bit record most users of this FIFO carry.
package fifo_pkg;

  localparam int FIFO_W_DEFAULT  = 33;
  localparam int FIFO_AW_DEFAULT = 11;
  localparam int FIFO_CW_DEFAULT = 16;
  localparam int FIFO_EVT_W      = 33;

  typedef logic [FIFO_EVT_W-1:0] evt_word_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The output register can be cleared synchronously so an empty read returns zero.
module fifo_sdp_ram #(
  parameter int W  = 33,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  input  logic          i_rclr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [W-1:0] r_rdata;

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read-before-write: a same-address read returns the previously stored word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else if (i_rclr) begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with sticky overflow/underflow flags, a saturating drop
// counter, a registered nearly-full flag and a high-water mark.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int W  = FIFO_W_DEFAULT,
  parameter int AW = FIFO_AW_DEFAULT,
  parameter int CW = FIFO_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  input  logic          wen,
  input  logic          ren,
  input  logic          flush,
  input  logic          clr,
  input  logic [AW:0]   afull_thr,
  output logic [W-1:0]  q,
  output logic          nempty,
  output logic          full,
  output logic          nearlyfull,
  output logic [AW:0]   nwords,
  output logic [AW:0]   hiwater,
  output logic          ovf,
  output logic          udf,
  output logic [CW-1:0] ndrop
);

  localparam logic [AW:0]   L_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
  localparam logic [CW-1:0] L_DMAX  = {CW{1'b1}};

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW:0]   r_hiwater;
  logic          r_nearlyfull;
  logic          r_ovf;
  logic          r_udf;
  logic [CW-1:0] r_ndrop;

  logic [AW:0]   w_count;
  logic [AW:0]   w_nextCount;
  logic          w_rdOk;
  logic          w_wrOk;
  logic          w_refused;
  logic          w_underflow;

  // Flush masks every request, so it never counts as a drop or an underflow.
  assign w_count     = r_wptr - r_rptr;
  assign w_rdOk      = ren && !flush && (w_count != '0);
  assign w_wrOk      = wen && !flush && ((w_count != L_DEPTH) || w_rdOk);
  assign w_refused   = wen && !flush && !w_wrOk;
  assign w_underflow = ren && !flush && (w_count == '0);

  always_comb begin
    w_nextCount = w_count;
    if (flush) begin
      w_nextCount = '0;
    end else begin
      unique case ({w_wrOk, w_rdOk})
        2'b10:   w_nextCount = w_count + L_ONE;
        2'b01:   w_nextCount = w_count - L_ONE;
        default: w_nextCount = w_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wrOk) begin
        r_wptr <= r_wptr + L_ONE;
      end
      if (w_rdOk) begin
        r_rptr <= r_rptr + L_ONE;
      end
    end
  end

  fifo_sdp_ram #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wrOk),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (d),
    .i_re    (w_rdOk),
    .i_raddr (r_rptr[AW-1:0]),
    .i_rclr  (w_underflow),
    .o_rdata (q)
  );

  // A same-cycle event beats clr, so the flag or counter shows that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_ndrop      <= '0;
      r_hiwater    <= '0;
      r_nearlyfull <= 1'b0;
    end else begin
      r_nearlyfull <= (w_nextCount >= afull_thr);

      if (w_refused) begin
        r_ovf <= 1'b1;
      end else if (clr) begin
        r_ovf <= 1'b0;
      end

      if (w_underflow) begin
        r_udf <= 1'b1;
      end else if (clr) begin
        r_udf <= 1'b0;
      end

      if (clr) begin
        r_ndrop <= w_refused ? CW'(1) : '0;
      end else if (w_refused && (r_ndrop != L_DMAX)) begin
        r_ndrop <= r_ndrop + CW'(1);
      end

      if (clr || (w_nextCount > r_hiwater)) begin
        r_hiwater <= w_nextCount;
      end
    end
  end

  assign nempty     = (w_count != '0);
  assign full       = (w_count == L_DEPTH);
  assign nwords     = w_count;
  assign hiwater    = r_hiwater;
  assign nearlyfull = r_nearlyfull;
  assign ovf        = r_ovf;
  assign udf        = r_udf;
  assign ndrop      = r_ndrop;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at W=33, AW=4: a queue model predicts
// every output after each clock and after asynchronous reset.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int W     = 33;
  localparam int AW    = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  d = '0;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic          flush = 1'b0;
  logic          clr = 1'b0;
  logic [AW:0]   afull_thr = 5'd16;
  logic [W-1:0]  q;
  logic          nempty;
  logic          full;
  logic          nearlyfull;
  logic [AW:0]   nwords;
  logic [AW:0]   hiwater;
  logic          ovf;
  logic          udf;
  logic [CW-1:0] ndrop;

  int vectors = 0;
  int miscompares = 0;

  evt_word_t   sbQ[$];
  evt_word_t   mQ = '0;
  logic        mOvf = 1'b0;
  logic        mUdf = 1'b0;
  logic        mNf = 1'b0;
  int          mNdrop = 0;
  int          mHi = 0;

  sync_fifo_param #(.W(W), .AW(AW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .wen        (wen),
    .ren        (ren),
    .flush      (flush),
    .clr        (clr),
    .afull_thr  (afull_thr),
    .q          (q),
    .nempty     (nempty),
    .full       (full),
    .nearlyfull (nearlyfull),
    .nwords     (nwords),
    .hiwater    (hiwater),
    .ovf        (ovf),
    .udf        (udf),
    .ndrop      (ndrop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll(input string ph);
    int n;
    n = sbQ.size();
    checkOutput({ph, ".q"},          64'(q),          64'(mQ));
    checkOutput({ph, ".nwords"},     64'(nwords),     64'(n));
    checkOutput({ph, ".nempty"},     64'(nempty),     64'(n != 0));
    checkOutput({ph, ".full"},       64'(full),       64'(n == DEPTH));
    checkOutput({ph, ".nearlyfull"}, 64'(nearlyfull), 64'(mNf));
    checkOutput({ph, ".hiwater"},    64'(hiwater),    64'(mHi));
    checkOutput({ph, ".ovf"},        64'(ovf),        64'(mOvf));
    checkOutput({ph, ".udf"},        64'(udf),        64'(mUdf));
    checkOutput({ph, ".ndrop"},      64'(ndrop),      64'(mNdrop));
  endtask

  // One clock of stimulus; the model predicts the post-edge state from the
  // pre-edge state, then all outputs are compared 1 time unit after the edge.
  task automatic applyStimulus(input string ph, input logic iWen, input logic iRen,
                               input evt_word_t iD, input logic iFlush, input logic iClr);
    int  cnt;
    logic rdOk, wrOk, refused, under;
    wen = iWen; ren = iRen; d = iD; flush = iFlush; clr = iClr;
    cnt = sbQ.size();
    refused = 1'b0;
    under = 1'b0;
    if (iFlush) begin
      sbQ.delete();
    end else begin
      rdOk = iRen && (cnt > 0);
      wrOk = iWen && ((cnt < DEPTH) || rdOk);
      refused = iWen && !wrOk;
      under = iRen && (cnt == 0);
      if (rdOk) mQ = sbQ.pop_front();
      else if (iRen) mQ = '0;
      if (wrOk) sbQ.push_back(iD);
    end
    if (refused) mOvf = 1'b1; else if (iClr) mOvf = 1'b0;
    if (under) mUdf = 1'b1; else if (iClr) mUdf = 1'b0;
    if (iClr) mNdrop = refused ? 1 : 0;
    else if (refused && mNdrop < 65535) mNdrop++;
    mNf = (sbQ.size() >= int'(afull_thr));
    if (iClr || sbQ.size() > mHi) mHi = sbQ.size();
    @(posedge clk);
    #1;
    checkAll(ph);
  endtask

  task automatic pulseReset(input string ph);
    #2;
    rst = 1'b1;
    #1;
    sbQ.delete();
    mQ = '0; mOvf = 1'b0; mUdf = 1'b0; mNf = 1'b0; mNdrop = 0; mHi = 0;
    checkAll(ph);
    wen = 1'b0; ren = 1'b0; flush = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    evt_word_t w;
    int k;
    #2;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      w = 33'h1_0000_0000 + 33'(i);
      applyStimulus("fill", 1'b1, 1'b0, w, 1'b0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, 1'b1, '0, 1'b0, 1'b0);

    // Full with simultaneous read/write, then refused writes and clr.
    for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 1'b1, 1'b0, 33'(100 + i), 1'b0, 1'b0);
    applyStimulus("fullRW", 1'b1, 1'b1, 33'h1_2345_6789, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("ovf", 1'b1, 1'b0, 33'h0_dead, 1'b0, 1'b0);
    applyStimulus("clr", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus("idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus("clrOvf", 1'b1, 1'b0, 33'h0_beef, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain2", 1'b0, 1'b1, '0, 1'b0, 1'b0);

    // Empty read with simultaneous write: no fall-through.
    applyStimulus("udf", 1'b1, 1'b1, 33'h5, 1'b0, 1'b0);
    applyStimulus("afterUdf", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    applyStimulus("holdQ", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Nearly-full threshold and flush.
    afull_thr = 5'd12;
    for (int i = 0; i < 12; i++) applyStimulus("afull", 1'b1, 1'b0, 33'(200 + i), 1'b0, 1'b0);
    applyStimulus("flushRW", 1'b1, 1'b1, 33'h7, 1'b1, 1'b0);
    applyStimulus("postFlush", 1'b1, 1'b0, 33'h1_1111_1111, 1'b0, 1'b0);
    applyStimulus("postFlushRd", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    afull_thr = 5'd0;
    applyStimulus("thrZero", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    afull_thr = 5'd4;

    // Stream 100 words with occupancy cycling 0..5; reset part way.
    k = 0;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 5; i++) begin
        applyStimulus("stream", 1'b1, 1'b0, 33'h1_0000_0000 ^ 33'(k * 7919), 1'b0, 1'b0);
        k++;
      end
      if (r == 12) begin
        pulseReset("midReset");
        applyStimulus("rstWr", 1'b1, 1'b0, 33'h1_cafe_f00d, 1'b0, 1'b0);
        applyStimulus("rstRd", 1'b0, 1'b1, '0, 1'b0, 1'b0);
      end else begin
        for (int i = 0; i < 5; i++) applyStimulus("stream", 1'b0, 1'b1, '0, 1'b0, 1'b0);
      end
    end

    // Random traffic biased toward filling.
    for (int i = 0; i < 300; i++) begin
      w = {1'($urandom_range(1)), 32'($urandom())};
      afull_thr = 5'($urandom_range(16));
      applyStimulus("rand", ($urandom_range(9) < 6), ($urandom_range(9) < 4), w,
                    ($urandom_range(63) == 0), ($urandom_range(15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
